// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port RAM between an instruction-fetch port and a data
// (load/store) port. A three-state FSM (IDLE / FETCH / DATA) grants one
// requester at a time, latches its address/we/wdata for the RAM, waits for
// ram_ready and returns a one-cycle ack plus registered read data.
//
// Arbitration: data normally wins, but after STARVE_MAX consecutive data
// grants taken while a fetch was pending, fetch is given priority. A grant
// that sees no ram_ready for MAX_WAIT busy cycles is aborted: the ack still
// pulses, the read data is forced to 0 (NOP) and the sticky err flag is set.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   if_req     in   fetch request (held until if_ack)
//   if_addr    in   fetch word address
//   mem_req    in   data request (held until mem_ack)
//   mem_we     in   1 = store, 0 = load
//   mem_addr   in   data address
//   mem_wdata  in   store data
//   ram_rdata  in   RAM read data
//   ram_ready  in   RAM completes the current access this cycle
//   ram_en     out  RAM access active (FETCH or DATA)
//   ram_we     out  RAM write strobe
//   ram_addr   out  RAM address
//   ram_wdata  out  RAM write data
//   if_ack     out  one-cycle fetch completion pulse
//   if_rdata   out  fetched instruction
//   mem_ack    out  one-cycle data completion pulse
//   mem_rdata  out  load data
//   stall_if   out  fetch waiting
//   stall_mem  out  data access waiting
//   err        out  sticky timeout flag
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned MAX_WAIT   = 16,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ready,
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        mem_ack,
  output logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        err
);

  localparam int unsigned WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WW-1:0] WAIT_LAST  = WW'(MAX_WAIT - 1);
  localparam logic [2:0]    STARVE_LIM = 3'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_e;

  state_e         state_q,     state_d;
  logic [31:0]    addr_q,      addr_d;
  logic           we_q,        we_d;
  logic [31:0]    wdata_q,     wdata_d;
  logic [WW-1:0]  wait_cnt_q,  wait_cnt_d;
  logic [2:0]     starve_q,    starve_d;
  logic           err_q,       err_d;
  logic           if_ack_q,    if_ack_d;
  logic           mem_ack_q,   mem_ack_d;
  logic [31:0]    if_rdata_q,  if_rdata_d;
  logic [31:0]    mem_rdata_q, mem_rdata_d;
  logic           ram_en_q,    ram_en_d;
  logic           ram_we_q,    ram_we_d;

  logic data_elig_s;
  logic fetch_elig_s;
  logic grant_data_s;
  logic grant_fetch_s;

  // IDLE arbitration: a requester in its own ack cycle is not eligible, so
  // the port just served cannot be re-granted on its stale request.
  always_comb begin
    data_elig_s   = mem_req & ~mem_ack_q;
    fetch_elig_s  = if_req  & ~if_ack_q;
    grant_data_s  = 1'b0;
    grant_fetch_s = 1'b0;
    if (data_elig_s && (starve_q < STARVE_LIM)) begin
      grant_data_s = 1'b1;
    end else if (fetch_elig_s) begin
      grant_fetch_s = 1'b1;
    end else if (data_elig_s) begin
      grant_data_s = 1'b1;
    end else begin
      grant_data_s  = 1'b0;
      grant_fetch_s = 1'b0;
    end
  end

  // Next-state, grant latching, completion and timeout handling.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    wait_cnt_d  = wait_cnt_q;
    starve_d    = starve_q;
    err_d       = err_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant_data_s) begin
          state_d    = DATA;
          addr_d     = mem_addr;
          we_d       = mem_we;
          wdata_d    = mem_wdata;
          wait_cnt_d = {WW{1'b0}};
          // Count data grants that overtook a pending fetch; saturating.
          if (if_req && (starve_q < STARVE_LIM)) begin
            starve_d = starve_q + 3'd1;
          end else begin
            starve_d = starve_q;
          end
        end else if (grant_fetch_s) begin
          state_d    = FETCH;
          addr_d     = if_addr;
          we_d       = 1'b0;
          wdata_d    = 32'd0;
          wait_cnt_d = {WW{1'b0}};
          starve_d   = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end

      FETCH, DATA: begin
        if (ram_ready) begin
          state_d = IDLE;
          if (state_q == FETCH) begin
            if_ack_d   = 1'b1;
            if_rdata_d = ram_rdata;
          end else begin
            mem_ack_d = 1'b1;
            // Stores leave the load-data register untouched.
            if (!we_q) begin
              mem_rdata_d = ram_rdata;
            end else begin
              mem_rdata_d = mem_rdata_q;
            end
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          // Timeout: complete the handshake with a NOP so the pipeline moves on.
          state_d = IDLE;
          err_d   = 1'b1;
          if (state_q == FETCH) begin
            if_ack_d   = 1'b1;
            if_rdata_d = 32'd0;
          end else begin
            mem_ack_d   = 1'b1;
            mem_rdata_d = 32'd0;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + WW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    ram_en_d = (state_d != IDLE);
    ram_we_d = (state_d == DATA) && we_d;
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= 32'd0;
      we_q        <= 1'b0;
      wdata_q     <= 32'd0;
      wait_cnt_q  <= {WW{1'b0}};
      starve_q    <= 3'd0;
      err_q       <= 1'b0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_rdata_q  <= 32'd0;
      mem_rdata_q <= 32'd0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      wait_cnt_q  <= wait_cnt_d;
      starve_q    <= starve_d;
      err_q       <= err_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
    end
  end

  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign if_ack    = if_ack_q;
  assign mem_ack   = mem_ack_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign err       = err_q;
  assign stall_if  = if_req  & ~if_ack_q;
  assign stall_mem = mem_req & ~mem_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int MAX_WAIT   = 16;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic [31:0] ram_rdata = 32'd0;
  logic        ram_ready = 1'b0;
  logic        ram_en, ram_we, if_ack, mem_ack, stall_if, stall_mem, err;
  logic [31:0] ram_addr, ram_wdata, if_rdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_WAIT(MAX_WAIT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .ram_rdata(ram_rdata), .ram_ready(ram_ready),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .if_ack(if_ack), .if_rdata(if_rdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // owner: 0 = nobody holds the RAM, 1 = fetch port, 2 = data port
  int          m_owner;
  int          m_busy;     // busy cycles already spent without ram_ready
  int          m_starve;   // data grants taken over a pending fetch
  bit          m_err, m_if_ack, m_mem_ack, m_we;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_mem_rdata;

  function automatic void model_reset();
    m_owner = 0; m_busy = 0; m_starve = 0; m_err = 1'b0;
    m_if_ack = 1'b0; m_mem_ack = 1'b0; m_we = 1'b0;
    m_addr = 32'd0; m_wdata = 32'd0; m_if_rdata = 32'd0; m_mem_rdata = 32'd0;
  endfunction

  // One clock edge worth of behaviour, computed from the inputs seen at the edge.
  function automatic void model_step();
    bit f_ack, d_ack, d_ok, f_ok, done, abort;
    int pick;
    if (!reset) begin
      model_reset();
      return;
    end
    f_ack = 1'b0;
    d_ack = 1'b0;
    if (m_owner == 0) begin
      d_ok = mem_req && !m_mem_ack;
      f_ok = if_req && !m_if_ack;
      pick = 0;
      if (d_ok && m_starve < STARVE_MAX) pick = 2;
      else if (f_ok) pick = 1;
      else if (d_ok) pick = 2;
      if (pick == 2) begin
        m_addr = mem_addr; m_we = mem_we; m_wdata = mem_wdata;
        if (if_req && m_starve < STARVE_MAX) m_starve++;
      end
      if (pick == 1) begin
        m_addr = if_addr; m_we = 1'b0; m_wdata = 32'd0; m_starve = 0;
      end
      m_owner = pick;
      m_busy = 0;
    end else begin
      done  = ram_ready;
      abort = !ram_ready && (m_busy + 1 == MAX_WAIT);
      if (done || abort) begin
        if (m_owner == 1) begin
          f_ack = 1'b1;
          m_if_rdata = abort ? 32'd0 : ram_rdata;
        end else begin
          d_ack = 1'b1;
          if (abort) m_mem_rdata = 32'd0;
          else if (!m_we) m_mem_rdata = ram_rdata;
        end
        if (abort) m_err = 1'b1;
        m_owner = 0;
      end else begin
        m_busy++;
      end
    end
    m_if_ack = f_ack;
    m_mem_ack = d_ack;
  endfunction

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ram_en",    32'(ram_en),    32'(m_owner != 0));
      chk("ram_we",    32'(ram_we),    32'(m_owner == 2 && m_we));
      chk("ram_addr",  ram_addr,       m_addr);
      chk("ram_wdata", ram_wdata,      m_wdata);
      chk("if_ack",    32'(if_ack),    32'(m_if_ack));
      chk("mem_ack",   32'(mem_ack),   32'(m_mem_ack));
      chk("if_rdata",  if_rdata,       m_if_rdata);
      chk("mem_rdata", mem_rdata,      m_mem_rdata);
      chk("stall_if",  32'(stall_if),  32'(if_req && !m_if_ack));
      chk("stall_mem", 32'(stall_mem), 32'(mem_req && !m_mem_ack));
      chk("err",       32'(err),       32'(m_err));
    end
  end

  // Advance to 1 time unit after the next rising edge, keeping the model in step.
  task automatic next_cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  bit f_active, f_done, d_active, d_done;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    #12;
    chk("rst_ram_en",  32'(ram_en), 32'd0);
    chk("rst_ram_adr", ram_addr,    32'd0);
    chk("rst_if_ack",  32'(if_ack), 32'd0);
    chk("rst_err",     32'(err),    32'd0);
    next_cycle();
    reset = 1'b1;
    cmp_en = 1'b1;
    settle();

    // Lone fetch: ack two cycles after the request.
    next_cycle(); if_req = 1'b1; if_addr = 32'h10; settle();
    chk("lf_stall0", 32'(stall_if), 32'd1);
    chk("lf_en0",    32'(ram_en),   32'd0);
    next_cycle(); ram_ready = 1'b1; ram_rdata = 32'hAAAA_AAAA; settle();
    chk("lf_en1",    32'(ram_en),   32'd1);
    chk("lf_addr",   ram_addr,      32'h10);
    chk("lf_stall1", 32'(stall_if), 32'd1);
    next_cycle(); ram_ready = 1'b0; settle();
    chk("lf_ack",    32'(if_ack),   32'd1);
    chk("lf_rdata",  if_rdata,      32'hAAAA_AAAA);
    chk("lf_stall2", 32'(stall_if), 32'd0);
    next_cycle(); if_req = 1'b0; settle();
    chk("lf_ack_end", 32'(if_ack), 32'd0);

    // Simultaneous requests: data first, fetch right after mem_ack.
    next_cycle();
    if_req = 1'b1; if_addr = 32'h100;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h40; mem_wdata = 32'd0;
    settle();
    next_cycle(); ram_ready = 1'b1; ram_rdata = 32'h5555_0040; settle();
    chk("sim_data_addr", ram_addr,    32'h40);
    chk("sim_data_we",   32'(ram_we), 32'd0);
    next_cycle(); ram_ready = 1'b0; settle();
    chk("sim_mem_ack",   32'(mem_ack), 32'd1);
    chk("sim_mem_rdata", mem_rdata,    32'h5555_0040);
    chk("sim_if_ack0",   32'(if_ack),  32'd0);
    next_cycle(); mem_req = 1'b0; ram_ready = 1'b1; ram_rdata = 32'h77; settle();
    chk("sim_fetch_en",   32'(ram_en), 32'd1);
    chk("sim_fetch_addr", ram_addr,    32'h100);
    next_cycle(); ram_ready = 1'b0; settle();
    chk("sim_if_ack",   32'(if_ack), 32'd1);
    chk("sim_if_rdata", if_rdata,    32'h77);
    next_cycle(); if_req = 1'b0; settle();

    // Store: write strobe and data, load-data register untouched.
    next_cycle(); mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h80; mem_wdata = 32'h1234_5678; settle();
    next_cycle(); ram_ready = 1'b1; ram_rdata = 32'hDEAD_BEEF; settle();
    chk("st_we",    32'(ram_we), 32'd1);
    chk("st_wdata", ram_wdata,   32'h1234_5678);
    next_cycle(); ram_ready = 1'b0; settle();
    chk("st_ack",   32'(mem_ack), 32'd1);
    chk("st_rdata", mem_rdata,    32'h5555_0040);
    next_cycle(); mem_req = 1'b0; mem_we = 1'b0; settle();

    // Starvation: four data grants overtake a fetch, then fetch wins.
    for (int i = 0; i < 4; i++) begin
      next_cycle(); mem_req = 1'b1; mem_addr = 32'h300 + 32'(4 * i); if_req = 1'b1; if_addr = 32'h400; settle();
      next_cycle(); ram_ready = 1'b1; ram_rdata = 32'(i); if_req = 1'b0; settle();
      chk("stv_data_addr", ram_addr, 32'h300 + 32'(4 * i));
      next_cycle(); ram_ready = 1'b0; settle();
      chk("stv_mem_ack", 32'(mem_ack), 32'd1);
    end
    next_cycle(); mem_addr = 32'h310; if_req = 1'b1; settle();
    next_cycle(); ram_ready = 1'b1; mem_req = 1'b0; settle();
    chk("stv_fetch_addr", ram_addr,    32'h400);
    chk("stv_fetch_we",   32'(ram_we), 32'd0);
    next_cycle(); ram_ready = 1'b0; settle();
    chk("stv_if_ack", 32'(if_ack), 32'd1);
    next_cycle(); if_req = 1'b0; settle();
    // Counter cleared by the fetch grant: data wins again.
    next_cycle(); mem_req = 1'b1; mem_addr = 32'h320; if_req = 1'b1; if_addr = 32'h404; settle();
    next_cycle(); ram_ready = 1'b1; settle();
    chk("stv_clr_addr", ram_addr, 32'h320);
    next_cycle(); ram_ready = 1'b0; settle();
    next_cycle(); mem_req = 1'b0; ram_ready = 1'b1; settle();
    chk("stv_clr_fetch", ram_addr, 32'h404);
    next_cycle(); ram_ready = 1'b0; settle();
    next_cycle(); if_req = 1'b0; settle();

    // Timeout: abort on the 16th busy cycle.
    next_cycle(); if_req = 1'b1; if_addr = 32'h200; ram_ready = 1'b0; settle();
    next_cycle(); settle();
    chk("to_busy1", 32'(ram_en), 32'd1);
    for (int k = 2; k <= 16; k++) begin
      next_cycle(); settle();
      chk("to_busy", 32'(ram_en), 32'd1);
    end
    next_cycle(); settle();
    chk("to_ack",   32'(if_ack), 32'd1);
    chk("to_rdata", if_rdata,    32'd0);
    chk("to_err",   32'(err),    32'd1);
    next_cycle(); if_req = 1'b0; settle();
    repeat (3) next_cycle();
    settle();
    chk("to_err_sticky", 32'(err), 32'd1);

    // Reset in the second FETCH cycle, then the pending fetch is re-granted.
    next_cycle(); if_req = 1'b1; if_addr = 32'h500; settle();
    next_cycle(); settle();
    next_cycle(); settle();
    chk("rm_busy2", 32'(ram_en), 32'd1);
    reset = 1'b0;
    model_reset();
    #1;
    chk("rm_en",    32'(ram_en), 32'd0);
    chk("rm_addr",  ram_addr,    32'd0);
    chk("rm_err",   32'(err),    32'd0);
    chk("rm_ack",   32'(if_ack), 32'd0);
    chk("rm_rdata", if_rdata,    32'd0);
    next_cycle(); reset = 1'b1; settle();
    next_cycle(); ram_ready = 1'b1; ram_rdata = 32'hCAFE_0500; settle();
    chk("rm_regrant", ram_addr,    32'h500);
    chk("rm_en2",     32'(ram_en), 32'd1);
    next_cycle(); ram_ready = 1'b0; settle();
    chk("rm_if_ack", 32'(if_ack), 32'd1);
    chk("rm_rdata2", if_rdata,    32'hCAFE_0500);
    next_cycle(); if_req = 1'b0; settle();

    // Randomized traffic from two protocol-following requesters.
    f_active = 1'b0; f_done = 1'b0; d_active = 1'b0; d_done = 1'b0;
    for (int c = 0; c < 2500; c++) begin
      next_cycle();
      if (f_active) begin
        if (m_if_ack) f_done = 1'b1;
        else if (f_done) begin f_active = 1'b0; if_req = 1'b0; end
      end
      if (!f_active && $urandom_range(0, 2) == 0) begin
        f_active = 1'b1; f_done = 1'b0; if_req = 1'b1; if_addr = $urandom;
      end
      if (d_active) begin
        if (m_mem_ack) d_done = 1'b1;
        else if (d_done) begin d_active = 1'b0; mem_req = 1'b0; end
      end
      if (!d_active && $urandom_range(0, 1) == 0) begin
        d_active = 1'b1; d_done = 1'b0; mem_req = 1'b1;
        mem_we = 1'($urandom_range(0, 1)); mem_addr = $urandom; mem_wdata = $urandom;
      end
      if (c >= 1200 && c < 1260) ram_ready = 1'b0;
      else ram_ready = ($urandom_range(0, 3) != 0);
      ram_rdata = $urandom;
    end

    next_cycle(); if_req = 1'b0; mem_req = 1'b0; settle();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters: MAX_WAIT, 16, cycles a grant may wait for ram_ready before abort; STARVE_MAX, 4, consecutive data grants allowed while fetch is pending.
REQ-002 Ports, all inputs sampled and all registers clocked on the rising edge of clk:
  clk  in  1  single clock.
  reset  in  1  asynchronous, active-low; 0 = reset.
  if_req  in  1  fetch request; held high with if_addr stable until if_ack.
  if_addr  in  32  fetch word address.
  mem_req  in  1  data request; held high with mem_we/mem_addr/mem_wdata stable until mem_ack.
  mem_we  in  1  1 = store, 0 = load.
  mem_addr  in  32  data address.
  mem_wdata  in  32  store data.
  ram_rdata  in  32  read data from the shared single-port RAM.
  ram_ready  in  1  RAM completes the current access in this cycle.
  ram_en  out  1  RAM access active.
  ram_we  out  1  RAM write strobe.
  ram_addr  out  32  RAM address.
  ram_wdata  out  32  RAM write data.
  if_ack  out  1  one-cycle fetch completion pulse.
  if_rdata  out  32  fetched instruction.
  mem_ack  out  1  one-cycle data completion pulse.
  mem_rdata  out  32  load data.
  stall_if  out  1  fetch waiting; drives disable_PC and disable_IR.
  stall_mem  out  1  data access waiting; freezes EX/MEM and everything upstream of it.
  err  out  1  sticky timeout flag.

Function
REQ-003 FSM states are IDLE, FETCH and DATA; no access is ever issued in IDLE.
REQ-004 IDLE eligibility: a requester is eligible when its req=1 and its ack is not high in the current cycle, so the requester just served is never re-granted in its own ack cycle.
REQ-005 IDLE priority: data wins if eligible and starve_cnt<STARVE_MAX; otherwise fetch wins if eligible; otherwise data wins if eligible; otherwise stay in IDLE.
REQ-006 On a grant, latch address, we and wdata (fetch: we=0, wdata=0) into registers that drive ram_addr, ram_we and ram_wdata.
REQ-007 ram_en=1 exactly in FETCH and DATA; ram_we=latched we in DATA, 0 otherwise.
REQ-008 In FETCH or DATA with ram_ready=1, return to IDLE at the clock edge and pulse the matching ack for the following cycle.
REQ-009 On a fetch completion, register if_rdata<=ram_rdata.
REQ-010 On a data completion, register mem_rdata<=ram_rdata for loads only; mem_rdata holds its value on stores.
REQ-011 Minimum latency is 2 cycles from request to ack: grant edge, ram_ready in the first busy cycle, ack in the next cycle.
REQ-012 wait_cnt clears on every grant and increments each busy cycle without ram_ready.
REQ-013 When wait_cnt reaches MAX_WAIT-1 in a busy cycle without ram_ready, abort: return to IDLE, pulse ack, set err=1, and load the read data register with 0 (NOP). err stays 1 until reset.
REQ-014 starve_cnt is 3 bits: +1 on each data grant while if_req=1; cleared on each fetch grant; saturates at STARVE_MAX.
REQ-015 stall_if = if_req & ~if_ack and stall_mem = mem_req & ~mem_ack, both combinational.
REQ-016 If mem_req and if_req rise in the same cycle, data is granted first (subject to REQ-005) and fetch follows immediately after mem_ack.
REQ-017 ram_ready in IDLE is ignored and produces no ack.

Reset
REQ-018 While reset=0, immediately and independent of clk: state=IDLE, wait_cnt=0, starve_cnt=0, err=0, ram_addr/ram_wdata/if_rdata/mem_rdata=0, ram_we=0, if_ack=0, mem_ack=0.
REQ-019 Reset asserted mid-access drops the transaction with no ack; after release the arbiter re-arbitrates whatever requests are pending.

Verification
REQ-020 Lone fetch: if_req, if_addr=0x10, ram_ready=1 with ram_rdata=0xAAAAAAAA in the first FETCH cycle -> if_ack 2 cycles after the request, if_rdata=0xAAAAAAAA, stall_if high only before the ack.
REQ-021 Simultaneous if_req and mem_req (load, addr 0x40, RAM 1-cycle) -> DATA granted first, mem_ack first, then FETCH with no IDLE gap cycle beyond the ack cycle.
REQ-022 Starvation: mem_req held with new accesses back-to-back and if_req high -> after 4 data grants, fetch granted; starve_cnt then 0.
REQ-023 Timeout: grant FETCH with ram_ready held 0 -> abort on the 16th busy cycle, if_ack pulses with if_rdata=0, and err stays 1.
REQ-024 Store: mem_we=1, mem_wdata=0x12345678 -> ram_we=1 and ram_wdata=0x12345678 during DATA; mem_rdata unchanged after mem_ack.
REQ-025 Reset pulled low in the second FETCH cycle -> all outputs at reset values asynchronously; no if_ack; after release, the pending if_req is re-granted.
